// File: rtl/mask_index_serializer.sv
// Serializes a 32-bit multi-hot mask into a stream of set-bit indices, one per
// output handshake, lowest-first or highest-first depending on LSB_FIRST.
module mask_index_serializer #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_mask,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_index,
    output logic [31:0] out_onehot,
    output logic        out_last,
    output logic [5:0]  out_remaining
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic [31:0] r_rem;
    logic [31:0] w_remNext;
    logic [4:0]  w_selIdx;
    logic [31:0] w_onehot;
    logic [5:0]  w_count;
    logic        w_beat;
    logic        w_accept;

    // Priority pick of the next bit: the last match in loop order wins.
    always_comb begin
        w_selIdx = '0;
        if (LSB_FIRST) begin
            for (int i = 31; i >= 0; i--) begin
                if (r_rem[i]) w_selIdx = 5'(i);
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (r_rem[i]) w_selIdx = 5'(i);
            end
        end
    end

    always_comb begin
        w_count = '0;
        for (int i = 0; i < 32; i++) begin
            w_count = w_count + 6'(r_rem[i]);
        end
    end

    assign out_valid     = (r_state == SCAN);
    assign w_onehot      = out_valid ? (32'd1 << w_selIdx) : 32'd0;
    assign out_onehot    = w_onehot;
    assign out_index     = out_valid ? w_selIdx : 5'd0;
    assign out_last      = out_valid && ((r_rem & ~w_onehot) == 32'd0);
    assign out_remaining = out_valid ? w_count : 6'd0;

    assign w_beat   = out_valid && out_ready;
    assign in_ready = !flush && ((r_state == IDLE) || (w_beat && out_last));
    assign w_accept = in_valid && in_ready;

    // A new mask can only be accepted while idle or on the final beat, so the
    // accept branch also covers the zero-bubble back-to-back handover.
    always_comb begin
        w_stateNext = r_state;
        w_remNext   = r_rem;
        if (flush) begin
            w_stateNext = IDLE;
            w_remNext   = '0;
        end else if (w_accept) begin
            w_remNext   = in_mask;
            w_stateNext = (in_mask != 32'd0) ? SCAN : IDLE;
        end else if (w_beat) begin
            w_remNext = r_rem & ~w_onehot;
            if (out_last) begin
                w_stateNext = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rem   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_rem   <= w_remNext;
        end
    end

endmodule

// File: tb/tb_mask_index_serializer.sv
// Randomized and directed bench for mask_index_serializer; both priority orders
// run side by side against a queue-of-indices reference model.
module tb_mask_index_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_mask;
    logic        flush;
    logic        out_ready;

    logic        aReady, aValid, aLast;
    logic [4:0]  aIndex;
    logic [31:0] aOnehot;
    logic [5:0]  aRemaining;
    logic        dReady, dValid, dLast;
    logic [4:0]  dIndex;
    logic [31:0] dOnehot;
    logic [5:0]  dRemaining;

    int testCount = 0;
    int failCount = 0;

    int ascQ[$];
    int descQ[$];

    mask_index_serializer #(.LSB_FIRST(1'b1)) dutAsc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(aReady),
        .in_mask(in_mask), .flush(flush), .out_valid(aValid), .out_ready(out_ready),
        .out_index(aIndex), .out_onehot(aOnehot), .out_last(aLast),
        .out_remaining(aRemaining)
    );

    mask_index_serializer #(.LSB_FIRST(1'b0)) dutDesc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(dReady),
        .in_mask(in_mask), .flush(flush), .out_valid(dValid), .out_ready(out_ready),
        .out_index(dIndex), .out_onehot(dOnehot), .out_last(dLast),
        .out_remaining(dRemaining)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll(input logic expReady);
        int n;
        n = ascQ.size();
        checkOutput("asc.in_ready", 32'(aReady), 32'(expReady));
        checkOutput("desc.in_ready", 32'(dReady), 32'(expReady));
        checkOutput("asc.out_valid", 32'(aValid), 32'(n != 0));
        checkOutput("desc.out_valid", 32'(dValid), 32'(n != 0));
        checkOutput("asc.out_remaining", 32'(aRemaining), 32'(n));
        checkOutput("desc.out_remaining", 32'(dRemaining), 32'(n));
        checkOutput("asc.out_last", 32'(aLast), 32'(n == 1));
        checkOutput("desc.out_last", 32'(dLast), 32'(n == 1));
        checkOutput("asc.out_index", 32'(aIndex), (n != 0) ? 32'(ascQ[0]) : 32'd0);
        checkOutput("desc.out_index", 32'(dIndex), (n != 0) ? 32'(descQ[0]) : 32'd0);
        checkOutput("asc.out_onehot", aOnehot, (n != 0) ? (32'd1 << ascQ[0]) : 32'd0);
        checkOutput("desc.out_onehot", dOnehot, (n != 0) ? (32'd1 << descQ[0]) : 32'd0);
    endtask

    // One cycle: drive inputs after the falling edge, check, then advance the
    // model across the rising edge using the handshakes that were offered.
    task automatic applyStimulus(input logic v, input logic [31:0] m,
                                 input logic ordy, input logic fl);
        logic expReady, accept, beat;
        @(negedge clk);
        in_valid  = v;
        in_mask   = m;
        out_ready = ordy;
        flush     = fl;
        #1;
        expReady = !fl && (ascQ.size() == 0 || (ordy && ascQ.size() == 1));
        checkAll(expReady);
        accept = v && expReady;
        beat   = (ascQ.size() != 0) && ordy;
        @(posedge clk);
        if (fl) begin
            ascQ.delete();
            descQ.delete();
        end else if (accept) begin
            ascQ.delete();
            descQ.delete();
            for (int i = 0; i < 32; i++) begin
                if (m[i]) begin
                    ascQ.push_back(i);
                    descQ.push_front(i);
                end
            end
        end else if (beat) begin
            void'(ascQ.pop_front());
            void'(descQ.pop_front());
        end
    endtask

    task automatic runMask(input logic [31:0] m, input int cycles);
        applyStimulus(1'b1, m, 1'b1, 1'b0);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    endtask

    function automatic logic [31:0] randomMask();
        logic [31:0] m;
        case ($urandom_range(0, 5))
            0: m = 32'd0;
            1: m = 32'd1 << $urandom_range(0, 31);
            2: m = $urandom() & $urandom() & $urandom();
            3: m = 32'hFFFF_FFFF;
            default: m = $urandom();
        endcase
        return m;
    endfunction

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mask   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #12;
        checkAll(1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        runMask(32'h0000_0001, 2);
        runMask(32'h8000_0011, 4);

        applyStimulus(1'b1, 32'h0000_0C00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);

        applyStimulus(1'b1, 32'h0000_0006, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h8000_0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        runMask(32'h0000_0000, 2);

        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h0000_00F0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);

        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        ascQ.delete();
        descQ.delete();
        checkAll(1'b1);
        #1;
        rst_n = 1'b1;
        runMask(32'h0000_0003, 3);

        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), randomMask(),
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
